// File: rtl/nec_ir_transmitter_pkg.sv
// Shared NEC IR definitions: segment lengths in timing units, the transmit
// FSM state type and clock-derived timing helpers. The receiver can share these.
package nec_pkg;

    // Segment lengths in 562.5 us timing units
    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int ONE_SPACE_U  = 3;
    localparam int BIT_U        = 1;
    localparam int FRAME_BITS   = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_STOP_MARK  = 3'd5,
        ST_GAP        = 3'd6
    } nec_tx_state_t;

    // Clock cycles per 562.5 us unit (9/16000 s)
    function automatic int unit_cycles(input longint clock_speed);
        longint c;
        c = (clock_speed * 64'd9) / 64'd16000;
        return int'(c);
    endfunction

    // Clock cycles per carrier half-period, never below one
    function automatic int half_cycles(input longint clock_speed, input longint carrier_hz);
        longint h;
        h = clock_speed / (64'd2 * carrier_hz);
        if (h < 64'd1) h = 64'd1;
        return int'(h);
    endfunction

    // True for the states in which the IR envelope is a mark
    function automatic logic is_mark_state(input nec_tx_state_t s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
    endfunction

endpackage

// File: rtl/nec_ir_transmitter_if.sv
// Command/status bundle of the NEC IR transmitter.
// Handshake: startIN / repeatIN are single-cycle strobes, accepted only while
// busyOUT is low (start wins if both are high); strobes seen while busyOUT is
// high are dropped. dataIN is sampled only on an accepted startIN. busyOUT
// rises the cycle after acceptance and falls the cycle after the doneOUT pulse.
interface nec_ir_transmitter_if;
    logic        startIN;
    logic        repeatIN;
    logic [31:0] dataIN;
    logic        busyOUT;
    logic        doneOUT;
    logic        markOUT;
    logic        txOUT;

    modport master (
        output startIN, repeatIN, dataIN,
        input  busyOUT, doneOUT, markOUT, txOUT
    );

    modport slave (
        input  startIN, repeatIN, dataIN,
        output busyOUT, doneOUT, markOUT, txOUT
    );
endinterface

// File: rtl/nec_ir_transmitter_carrier_gen.sv
// Carrier square-wave generator. restart forces the phase high and clears the
// divider so every mark opens with a full high half-period; while gate is low
// the phase is parked at 0.
module nec_carrier_gen #(
    parameter int HALF = 657
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic gate,
    output logic phase
);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;

    // Next divider count and phase
    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        if (restart) begin
            div_d   = '0;
            phase_d = 1'b1;
        end else if (!gate) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            phase_d = ~phase_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider and phase registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR frame encoder: leader, 32 MSB-first data bits and a stop mark (or the
// short repeat frame), followed by an idle gap. Every segment is a whole number
// of 562.5 us units; the unit counter restarts on each state entry.
module nec_ir_transmitter
    import nec_pkg::*;
#(
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int CARRIER_HZ  = 38_000,
    parameter bit CARRIER_EN  = 1'b1,
    parameter int GAP_UNITS   = 72
) (
    input  logic                 clkIN,
    input  logic                 resetIN,
    nec_ir_transmitter_if.slave  bus,
    output nec_tx_state_t        state_dbg
);
    localparam int UNIT_CYCLES = unit_cycles(CLOCK_SPEED);
    localparam int HALF        = half_cycles(CLOCK_SPEED, CARRIER_HZ);
    localparam int UNIT_W      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int SEG_MAX     = (GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U;
    localparam int SEG_W       = $clog2(SEG_MAX + 1);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);

    nec_tx_state_t     state_q, state_d;
    logic [UNIT_W-1:0] unit_cnt_q, unit_cnt_d;
    logic [SEG_W-1:0]  seg_cnt_q, seg_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              is_rep_q, is_rep_d;

    logic [SEG_W-1:0]  seg_len;
    logic              unit_end;
    logic              seg_end;
    logic              mark_now;
    logic              mark_next;
    logic              carrier;

    // Length in units of the segment the FSM is currently in
    always_comb begin
        seg_len = SEG_W'(BIT_U);
        case (state_q)
            ST_LEAD_MARK:  seg_len = SEG_W'(LEAD_MARK_U);
            ST_LEAD_SPACE: seg_len = is_rep_q ? SEG_W'(REP_SPACE_U) : SEG_W'(LEAD_SPACE_U);
            ST_BIT_SPACE:  seg_len = shift_q[31] ? SEG_W'(ONE_SPACE_U) : SEG_W'(BIT_U);
            ST_GAP:        seg_len = SEG_W'(GAP_UNITS);
            default:       seg_len = SEG_W'(BIT_U);
        endcase
    end

    assign unit_end = (unit_cnt_q == UNIT_LAST);
    assign seg_end  = unit_end && (seg_cnt_q == (seg_len - SEG_W'(1)));

    // Next state, timing counters and frame payload
    always_comb begin
        state_d    = state_q;
        unit_cnt_d = unit_cnt_q;
        seg_cnt_d  = seg_cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        is_rep_d   = is_rep_q;

        if (state_q != ST_IDLE) begin
            if (unit_end) begin
                unit_cnt_d = '0;
                seg_cnt_d  = seg_cnt_q + SEG_W'(1);
            end else begin
                unit_cnt_d = unit_cnt_q + UNIT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.startIN) begin
                    state_d   = ST_LEAD_MARK;
                    shift_d   = bus.dataIN;
                    bit_cnt_d = '0;
                    is_rep_d  = 1'b0;
                end else if (bus.repeatIN) begin
                    state_d   = ST_LEAD_MARK;
                    bit_cnt_d = '0;
                    is_rep_d  = 1'b1;
                end
            end
            ST_LEAD_MARK: begin
                if (seg_end) state_d = ST_LEAD_SPACE;
            end
            ST_LEAD_SPACE: begin
                if (seg_end) state_d = is_rep_q ? ST_STOP_MARK : ST_BIT_MARK;
            end
            ST_BIT_MARK: begin
                if (seg_end) state_d = ST_BIT_SPACE;
            end
            ST_BIT_SPACE: begin
                if (seg_end) begin
                    shift_d   = {shift_q[30:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
                end
            end
            ST_STOP_MARK: begin
                if (seg_end) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (seg_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every state entry starts a fresh whole-unit segment
        if (state_d != state_q) begin
            unit_cnt_d = '0;
            seg_cnt_d  = '0;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state_q    <= ST_IDLE;
            unit_cnt_q <= '0;
            seg_cnt_q  <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            is_rep_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            is_rep_q   <= is_rep_d;
        end
    end

    assign mark_now  = is_mark_state(state_q);
    assign mark_next = is_mark_state(state_d);

    // Restart the carrier on the edge that opens a mark, so the phase is
    // already high in the first mark cycle.
    nec_carrier_gen #(
        .HALF (HALF)
    ) u_carrier (
        .clk     (clkIN),
        .rst     (resetIN),
        .restart (mark_next && !mark_now),
        .gate    (mark_next),
        .phase   (carrier)
    );

    assign bus.busyOUT = (state_q != ST_IDLE);
    assign bus.doneOUT = (state_q == ST_GAP) && seg_end;
    assign bus.markOUT = mark_now;
    assign bus.txOUT   = CARRIER_EN ? (mark_now && carrier) : mark_now;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed bench for nec_ir_transmitter. dut_a runs at a 16 kHz clock
// (9 cycles per unit) without carrier; dut_b adds a 2 kHz carrier (4-cycle
// half-period) to check phase restart and space gating.
module tb_nec_ir_transmitter;
    import nec_pkg::*;

    localparam int UNIT = 9;
    localparam int GAPU = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    nec_tx_state_t st_a;
    nec_tx_state_t st_b;

    nec_ir_transmitter_if bus_a ();
    nec_ir_transmitter_if bus_b ();

    nec_ir_transmitter #(
        .CLOCK_SPEED (16000),
        .CARRIER_HZ  (38000),
        .CARRIER_EN  (1'b0),
        .GAP_UNITS   (GAPU)
    ) dut_a (
        .clkIN     (clk),
        .resetIN   (rst_a),
        .bus       (bus_a),
        .state_dbg (st_a)
    );

    nec_ir_transmitter #(
        .CLOCK_SPEED (16000),
        .CARRIER_HZ  (2000),
        .CARRIER_EN  (1'b1),
        .GAP_UNITS   (GAPU)
    ) dut_b (
        .clkIN     (clk),
        .resetIN   (rst_b),
        .bus       (bus_b),
        .state_dbg (st_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Busy-cycle and done-pulse counters for dut_a
    logic cnt_clr = 1'b0;
    int   busy_cyc = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (cnt_clr) begin
            busy_cyc <= 0;
            done_cnt <= 0;
        end else begin
            if (bus_a.busyOUT === 1'b1) busy_cyc <= busy_cyc + 1;
            if (bus_a.doneOUT === 1'b1) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Pulse strobes for one cycle; returns at the first negedge after acceptance
    task automatic send_a(input logic s, input logic r, input logic [31:0] d);
        @(negedge clk);
        bus_a.startIN  = s;
        bus_a.repeatIN = r;
        bus_a.dataIN   = d;
        @(negedge clk);
        bus_a.startIN  = 1'b0;
        bus_a.repeatIN = 1'b0;
    endtask

    // Count consecutive cycles at envelope level lvl, bounded
    task automatic measure_a(input logic lvl, input int exp_len, input string tag);
        int cnt = 0;
        while ((bus_a.markOUT === lvl) && (cnt < exp_len + 64)) begin
            cnt++;
            @(negedge clk);
        end
        check_val(tag, 32'(cnt), 32'(exp_len));
    endtask

    // Gap: space while busy, with one doneOUT pulse on its last cycle
    task automatic gap_a(input string tag);
        int cnt = 0;
        int done_at = -1;
        int ndone = 0;
        int mark_errs = 0;
        while ((bus_a.busyOUT === 1'b1) && (cnt < GAPU * UNIT + 64)) begin
            if (bus_a.doneOUT === 1'b1) begin
                done_at = cnt;
                ndone++;
            end
            if (bus_a.markOUT !== 1'b0) mark_errs++;
            cnt++;
            @(negedge clk);
        end
        check_val({tag, "_gap_len"}, 32'(cnt), 32'(GAPU * UNIT));
        check_val({tag, "_done_pos"}, 32'(done_at), 32'(GAPU * UNIT - 1));
        check_val({tag, "_done_count"}, 32'(ndone), 32'd1);
        check_val({tag, "_gap_mark"}, 32'(mark_errs), 32'd0);
        check_bit({tag, "_idle_done"}, bus_a.doneOUT, 1'b0);
        check_val({tag, "_idle_state"}, 32'(st_a), 32'(ST_IDLE));
    endtask

    task automatic bits_a(input logic [31:0] data, input int nbits, input string tag);
        for (int i = 31; i > 31 - nbits; i--) begin
            measure_a(1'b1, UNIT, $sformatf("%s_bit%0d_mark", tag, i));
            measure_a(1'b0, data[i] ? 3 * UNIT : UNIT, $sformatf("%s_bit%0d_space", tag, i));
        end
    endtask

    task automatic frame_a(input logic [31:0] data, input logic rep, input int lead_len, input string tag);
        measure_a(1'b1, lead_len, {tag, "_lead_mark"});
        measure_a(1'b0, rep ? 4 * UNIT : 8 * UNIT, {tag, "_lead_space"});
        if (!rep) bits_a(data, 32, tag);
        measure_a(1'b1, UNIT, {tag, "_stop_mark"});
        gap_a(tag);
    endtask

    // Carrier segment on dut_b: pattern of 4 high / 4 low inside marks, 0 in spaces
    task automatic carrier_seg_b(input logic lvl, input int len, input string tag);
        int errs = 0;
        logic exp_tx;
        check_bit({tag, "_first_tx"}, bus_b.txOUT, lvl);
        for (int k = 0; k < len; k++) begin
            exp_tx = lvl && (((k / 4) % 2) == 0);
            if ((bus_b.txOUT !== exp_tx) || (bus_b.markOUT !== lvl)) errs++;
            @(negedge clk);
        end
        check_val({tag, "_pattern_errs"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int busy_hi;

        bus_a.startIN  = 1'b0;
        bus_a.repeatIN = 1'b0;
        bus_a.dataIN   = '0;
        bus_b.startIN  = 1'b0;
        bus_b.repeatIN = 1'b0;
        bus_b.dataIN   = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_bit("rst_busy", bus_a.busyOUT, 1'b0);
        check_bit("rst_done", bus_a.doneOUT, 1'b0);
        check_bit("rst_mark", bus_a.markOUT, 1'b0);
        check_bit("rst_tx", bus_a.txOUT, 1'b0);
        check_val("rst_state", 32'(st_a), 32'(ST_IDLE));
        check_bit("rst_b_tx", bus_b.txOUT, 1'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // 1: full frame, 1-cycle latency
        send_a(1'b1, 1'b0, 32'h00ff906f);
        check_bit("t1_accept_busy", bus_a.busyOUT, 1'b1);
        check_bit("t1_accept_mark", bus_a.markOUT, 1'b1);
        check_bit("t1_accept_tx", bus_a.txOUT, 1'b1);
        frame_a(32'h00ff906f, 1'b0, 16 * UNIT, "t1");

        // 2: repeat frame, busy exactly 225 cycles
        cnt_clr = 1'b1;
        repeat (2) @(negedge clk);
        cnt_clr = 1'b0;
        send_a(1'b0, 1'b1, 32'hdeadbeef);
        frame_a(32'h0, 1'b1, 16 * UNIT, "t2");
        #1;
        check_val("t2_busy_cycles", 32'(busy_cyc), 32'd225);
        check_val("t2_done_pulses", 32'(done_cnt), 32'd1);

        // 3: both strobes -> full frame; start while busy ignored
        cnt_clr = 1'b1;
        repeat (2) @(negedge clk);
        cnt_clr = 1'b0;
        send_a(1'b1, 1'b1, 32'ha5c30f81);
        repeat (5) @(negedge clk);
        bus_a.startIN = 1'b1;
        bus_a.dataIN  = 32'hffffffff;
        @(negedge clk);
        bus_a.startIN = 1'b0;
        frame_a(32'ha5c30f81, 1'b0, 16 * UNIT - 6, "t3");
        busy_hi = 0;
        for (int k = 0; k < 300; k++) begin
            if (bus_a.busyOUT !== 1'b0) busy_hi++;
            @(negedge clk);
        end
        check_val("t3_no_second_frame", 32'(busy_hi), 32'd0);
        check_val("t3_done_pulses", 32'(done_cnt), 32'd1);

        // 4: reset in the middle of bit 10, then a clean frame
        send_a(1'b1, 1'b0, 32'h00ffa857);
        measure_a(1'b1, 16 * UNIT, "t4_lead_mark");
        measure_a(1'b0, 8 * UNIT, "t4_lead_space");
        bits_a(32'h00ffa857, 10, "t4");
        repeat (4) @(negedge clk);
        check_bit("t4_pre_rst_mark", bus_a.markOUT, 1'b1);
        rst_a = 1'b1;
        @(negedge clk);
        check_bit("t4_rst_tx", bus_a.txOUT, 1'b0);
        check_bit("t4_rst_mark", bus_a.markOUT, 1'b0);
        check_bit("t4_rst_busy", bus_a.busyOUT, 1'b0);
        check_val("t4_rst_state", 32'(st_a), 32'(ST_IDLE));
        rst_a = 1'b0;
        @(negedge clk);
        send_a(1'b1, 1'b0, 32'h00ffa857);
        frame_a(32'h00ffa857, 1'b0, 16 * UNIT, "t4b");

        // 5: carrier gating and phase restart on dut_b (repeat frame)
        @(negedge clk);
        bus_b.repeatIN = 1'b1;
        @(negedge clk);
        bus_b.repeatIN = 1'b0;
        carrier_seg_b(1'b1, 16 * UNIT, "t5_lead_mark");
        carrier_seg_b(1'b0, 4 * UNIT, "t5_lead_space");
        carrier_seg_b(1'b1, UNIT, "t5_stop_mark");
        carrier_seg_b(1'b0, GAPU * UNIT, "t5_gap");
        check_bit("t5_idle_busy", bus_b.busyOUT, 1'b0);
        check_bit("t5_idle_tx", bus_b.txOUT, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
